// File: rtl/mem_ctrl.sv
// Word-wide memory responder for the fetch and data ports, serialising
// each 32-bit access into four byte cycles on a byte-wide synchronous RAM.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ce_i,
    input  logic [31:0]       inst_addr_i,
    output logic [31:0]       inst_data_o,
    output logic              inst_ready_o,
    input  logic              data_ce_i,
    input  logic              data_we_i,
    input  logic [31:0]       data_addr_i,
    input  logic [3:0]        data_sel_i,
    input  logic [31:0]       data_wdata_i,
    output logic [31:0]       data_rdata_o,
    output logic              data_ready_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [7:0]        mem_dout_o,
    output logic              mem_wr_o,
    input  logic [7:0]        mem_din_i
);

    localparam int WW = ADDR_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDL,
        WR,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                port_q, port_d;
    logic [WW-1:0]       word_q, word_d;
    logic [3:0]          sel_q, sel_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [23:0]         buf_q, buf_d;
    logic [31:0]         inst_data_q, inst_data_d;
    logic                inst_ready_q, inst_ready_d;
    logic [31:0]         data_rdata_q, data_rdata_d;
    logic                data_ready_q, data_ready_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                mem_wr_q, mem_wr_d;
    logic [1:0]          cnt_inc;
    logic                unused_addr;

    assign unused_addr = ^{inst_addr_i[31:ADDR_W], inst_addr_i[1:0],
                           data_addr_i[31:ADDR_W], data_addr_i[1:0]};

    assign cnt_inc = cnt_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        word_d       = word_q;
        sel_d        = sel_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        inst_data_d  = inst_data_q;
        inst_ready_d = 1'b0;
        data_rdata_d = data_rdata_q;
        data_ready_d = 1'b0;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Data port has priority; a pending fetch waits its turn.
                if (data_ce_i) begin
                    port_d  = 1'b1;
                    word_d  = data_addr_i[ADDR_W-1:2];
                    sel_d   = data_sel_i;
                    wdata_d = data_wdata_i;
                    cnt_d   = 2'd0;
                    mem_a_d = {data_addr_i[ADDR_W-1:2], 2'b00};
                    if (data_we_i) begin
                        state_d    = WR;
                        mem_dout_d = data_wdata_i[7:0];
                        mem_wr_d   = data_sel_i[0];
                    end else begin
                        state_d = RD;
                    end
                end else if (inst_ce_i) begin
                    port_d  = 1'b0;
                    word_d  = inst_addr_i[ADDR_W-1:2];
                    cnt_d   = 2'd0;
                    mem_a_d = {inst_addr_i[ADDR_W-1:2], 2'b00};
                    state_d = RD;
                end
            end
            RD: begin
                // Read data trails the address by one cycle.
                unique case (cnt_q)
                    2'd1:    buf_d[7:0]   = mem_din_i;
                    2'd2:    buf_d[15:8]  = mem_din_i;
                    2'd3:    buf_d[23:16] = mem_din_i;
                    default: ;
                endcase
                cnt_d = cnt_inc;
                if (cnt_q == 2'd3) begin
                    state_d = RDL;
                end else begin
                    mem_a_d = {word_q, cnt_inc};
                end
            end
            RDL: begin
                state_d = DONE;
                if (port_q) begin
                    data_rdata_d = {mem_din_i, buf_q};
                    data_ready_d = 1'b1;
                end else begin
                    inst_data_d  = {mem_din_i, buf_q};
                    inst_ready_d = 1'b1;
                end
            end
            WR: begin
                cnt_d = cnt_inc;
                if (cnt_q == 2'd3) begin
                    state_d      = DONE;
                    data_ready_d = 1'b1;
                end else begin
                    mem_a_d    = {word_q, cnt_inc};
                    mem_dout_d = wdata_q[{cnt_inc, 3'b000} +: 8];
                    mem_wr_d   = sel_q[cnt_inc];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            port_q       <= 1'b0;
            word_q       <= '0;
            sel_q        <= 4'd0;
            wdata_q      <= 32'd0;
            buf_q        <= 24'd0;
            inst_data_q  <= 32'd0;
            inst_ready_q <= 1'b0;
            data_rdata_q <= 32'd0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            mem_a_q      <= '0;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            word_q       <= word_d;
            sel_q        <= sel_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            inst_data_q  <= inst_data_d;
            inst_ready_q <= inst_ready_d;
            data_rdata_q <= data_rdata_d;
            data_ready_q <= data_ready_d;
            busy_q       <= busy_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
        end
    end

    assign inst_data_o  = inst_data_q;
    assign inst_ready_o = inst_ready_q;
    assign data_rdata_o = data_rdata_q;
    assign data_ready_o = data_ready_q;
    assign busy_o       = busy_q;
    assign mem_a_o      = mem_a_q;
    assign mem_dout_o   = mem_dout_q;
    assign mem_wr_o     = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl against a byte-wide synchronous RAM model.
module tb_mem_ctrl;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_ce_i;
    logic [31:0]   inst_addr_i;
    logic [31:0]   inst_data_o;
    logic          inst_ready_o;
    logic          data_ce_i;
    logic          data_we_i;
    logic [31:0]   data_addr_i;
    logic [3:0]    data_sel_i;
    logic [31:0]   data_wdata_i;
    logic [31:0]   data_rdata_o;
    logic          data_ready_o;
    logic          busy_o;
    logic [AW-1:0] mem_a_o;
    logic [7:0]    mem_dout_o;
    logic          mem_wr_o;
    logic [7:0]    mem_din_i;

    logic          pre_we;
    logic [AW-1:0] pre_a;
    logic [7:0]    pre_d;

    logic [7:0] mem     [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;
    logic [31:0] last_drd;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_ce_i    (inst_ce_i),
        .inst_addr_i  (inst_addr_i),
        .inst_data_o  (inst_data_o),
        .inst_ready_o (inst_ready_o),
        .data_ce_i    (data_ce_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_sel_i   (data_sel_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .data_ready_o (data_ready_o),
        .busy_o       (busy_o),
        .mem_a_o      (mem_a_o),
        .mem_dout_o   (mem_dout_o),
        .mem_wr_o     (mem_wr_o),
        .mem_din_i    (mem_din_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        if (mem_wr_o) mem[mem_a_o] <= mem_dout_o;
        mem_din_i <= mem[mem_a_o];
    end

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic poke_word(input logic [AW-1:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) poke(a + AW'(k), w[8*k +: 8]);
    endtask

    task automatic apply(input int idx, input vec_t v);
        logic [AW-1:0] base;
        int rdy_cyc, pulses, other, wrs;
        logic addr_ok, dout_ok;
        logic [31:0] got;
        base = {v.addr[AW-1:2], 2'b00};
        rdy_cyc = -1; pulses = 0; other = 0; wrs = 0;
        addr_ok = 1'b1; dout_ok = 1'b1; got = 32'd0;
        if (v.is_data) begin
            data_ce_i = 1'b1; data_we_i = v.we; data_addr_i = v.addr;
            data_sel_i = v.sel; data_wdata_i = v.wdata;
        end else begin
            inst_ce_i = 1'b1; inst_addr_i = v.addr;
        end
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c <= 4 && mem_a_o !== base + AW'(c - 1)) addr_ok = 1'b0;
            if (mem_wr_o) begin
                wrs++;
                if (mem_a_o[AW-1:2] !== base[AW-1:2] ||
                    mem_dout_o !== v.wdata[8*mem_a_o[1:0] +: 8])
                    dout_ok = 1'b0;
            end
            if (v.is_data ? inst_ready_o : data_ready_o) other++;
            if (v.is_data ? data_ready_o : inst_ready_o) begin
                pulses++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = c;
                    got = v.is_data ? data_rdata_o : inst_data_o;
                end
                data_ce_i = 1'b0;
                inst_ce_i = 1'b0;
            end
        end
        data_ce_i = 1'b0;
        inst_ce_i = 1'b0;
        chk($sformatf("v%0d latency", idx), 64'(rdy_cyc), 64'(v.exp_lat));
        chk($sformatf("v%0d pulses", idx), 64'(pulses), 64'd1);
        chk($sformatf("v%0d other_port", idx), 64'(other), 64'd0);
        chk($sformatf("v%0d addr_seq", idx), 64'(addr_ok), 64'd1);
        if (v.we) begin
            for (int k = 0; k < 4; k++)
                if (v.sel[k]) ref_mem[base + AW'(k)] = v.wdata[8*k +: 8];
            chk($sformatf("v%0d wr_count", idx), 64'(wrs),
                64'($countones(v.sel)));
            chk($sformatf("v%0d wr_data", idx), 64'(dout_ok), 64'd1);
            chk($sformatf("v%0d mem", idx),
                64'({mem[base+3], mem[base+2], mem[base+1], mem[base]}),
                64'({ref_mem[base+3], ref_mem[base+2],
                     ref_mem[base+1], ref_mem[base]}));
            chk($sformatf("v%0d rdata_hold", idx), 64'(data_rdata_o),
                64'(last_drd));
        end else begin
            chk($sformatf("v%0d rdata", idx), 64'(got), 64'(v.exp_rdata));
            chk($sformatf("v%0d wr_count", idx), 64'(wrs), 64'd0);
            if (v.is_data) last_drd = v.exp_rdata;
        end
    endtask

    initial begin
        int d_cyc, i_cyc, d_n, i_n, n_rdy;
        logic [31:0] d_got, i_got;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0102, 4'h0, 32'h0, 32'h1234_5678, 6};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 4'b0100, 32'hAABB_CCDD, 32'h0, 5};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0203, 4'h0, 32'h0, 32'h44BB_2211, 6};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0300, 4'b0000, 32'hFFFF_FFFF, 32'h0, 5};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0300, 4'h0, 32'h0, 32'h3CC3_5AA5, 6};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0401, 4'b1001, 32'h9988_7766, 32'h0, 5};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0400, 4'h0, 32'h0, 32'h99A2_A166, 6};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFF_0104, 4'h0, 32'h0, 32'hDEAD_BEEF, 6};
        vecs[8] = '{1'b1, 1'b1, 32'h0001_0100, 4'b1111, 32'hCAFE_F00D, 32'h0, 5};
        vecs[9] = '{1'b1, 1'b0, 32'h0001_0102, 4'h0, 32'h0, 32'hCAFE_F00D, 6};

        rst = 1'b0;
        inst_ce_i = 1'b0; inst_addr_i = '0;
        data_ce_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0;
        data_sel_i = '0; data_wdata_i = '0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;
        last_drd = 32'd0;

        repeat (2) @(negedge clk);
        chk("reset_outputs",
            64'({inst_data_o, inst_ready_o, data_ready_o, busy_o, mem_wr_o}),
            64'd0);
        chk("reset_mem_bus", 64'({data_rdata_o, mem_a_o, mem_dout_o}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        poke_word(17'h00100, 32'h1234_5678);
        poke_word(17'h00200, 32'h4433_2211);
        poke_word(17'h00300, 32'h3CC3_5AA5);
        poke_word(17'h00400, 32'hA3A2_A1A0);
        poke_word(17'h10104, 32'hDEAD_BEEF);
        poke_word(17'h10100, 32'h0000_0000);
        poke_word(17'h00500, 32'h0403_0201);
        @(negedge clk);

        for (int i = 0; i < 10; i++) apply(i, vecs[i]);

        // Simultaneous requests: data first, fetch right after.
        d_cyc = -1; i_cyc = -1; d_n = 0; i_n = 0; d_got = 0; i_got = 0;
        data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0001_0104;
        inst_ce_i = 1'b1; inst_addr_i = 32'h0000_0102;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (data_ready_o) begin
                d_n++;
                if (d_cyc < 0) begin d_cyc = c; d_got = data_rdata_o; end
                data_ce_i = 1'b0;
            end
            if (inst_ready_o) begin
                i_n++;
                if (i_cyc < 0) begin i_cyc = c; i_got = inst_data_o; end
                inst_ce_i = 1'b0;
            end
        end
        data_ce_i = 1'b0; inst_ce_i = 1'b0;
        chk("cont data_lat", 64'(d_cyc), 64'd6);
        chk("cont inst_lat", 64'(i_cyc), 64'd13);
        chk("cont pulses", 64'({d_n[7:0], i_n[7:0]}), 64'h0101);
        chk("cont data", 64'(d_got), 64'hDEAD_BEEF);
        chk("cont inst", 64'(i_got), 64'h1234_5678);

        // Fetch request held for 20 cycles.
        n_rdy = 0;
        inst_ce_i = 1'b1; inst_addr_i = 32'h0000_0100;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            chk($sformatf("held busy c%0d", c), 64'(busy_o),
                64'(c <= 20 && (c % 7) != 0));
            chk($sformatf("held ready c%0d", c), 64'(inst_ready_o),
                64'(c == 6 || c == 13 || c == 20));
            if (inst_ready_o) begin
                n_rdy++;
                chk($sformatf("held data c%0d", c), 64'(inst_data_o),
                    64'h1234_5678);
            end
            if (c == 19) inst_ce_i = 1'b0;
        end
        chk("held pulses", 64'(n_rdy), 64'd3);

        // Reset during the second write cycle of a full-word write.
        data_ce_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h0000_0500;
        data_sel_i = 4'b1111; data_wdata_i = 32'h5566_7788;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        data_ce_i = 1'b0;
        #1;
        chk("rst_mid outputs",
            64'({inst_data_o, inst_ready_o, data_ready_o, busy_o, mem_wr_o}),
            64'd0);
        chk("rst_mid bus", 64'({data_rdata_o, mem_a_o, mem_dout_o}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid mem",
            64'({mem[17'h503], mem[17'h502], mem[17'h501], mem[17'h500]}),
            64'h0403_0288);
        rst = 1'b1;
        n_rdy = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (data_ready_o || inst_ready_o || busy_o) n_rdy++;
        end
        chk("rst_mid no_ready", 64'(n_rdy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
